// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- signal bundle between the sequencer and its environment.
//   run        : level enable (1 = sequence, 0 = park in IDLE after current instr)
//   imem_req   : instruction fetch request
//   imem_addr  : fetch address, always equal to pc
//   imem_ack   : fetch complete, imem_data valid in the same cycle
//   imem_data  : fetched instruction word
//   instr      : latched current instruction
//   exec_valid : one-cycle pulse issuing instr to the ALU
//   alu_done   : ALU finished, alu_result valid in the same cycle
//   alu_result : ALU result
//   pc         : program counter
//   halted     : high while halted
// master = sequencer side, slave = memory/ALU/control side.
interface pc_sequencer_if;
   logic        run;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        exec_valid;
   logic        alu_done;
   logic [15:0] alu_result;
   logic [7:0]  pc;
   logic        halted;

   modport master (
      input  run, imem_ack, imem_data, alu_done, alu_result,
      output imem_req, imem_addr, instr, exec_valid, pc, halted
   );

   modport slave (
      output run, imem_ack, imem_data, alu_done, alu_result,
      input  imem_req, imem_addr, instr, exec_valid, pc, halted
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch / execute / update instruction sequencer.
// Ports:
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : pc_sequencer_if.master (fetch handshake, ALU handshake, status)
// Flow: IDLE -> FETCH -> EXEC -> (WAIT_ALU ->) UPDATE -> FETCH/IDLE.
// A fetched HALT_OPCODE parks the sequencer in HALT until reset.
// Branches (instr[1:0]==2'b10) skip the ALU and test last_result.
module pc_sequencer #(
   parameter logic [7:0]  RESET_PC    = 8'h00,
   parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WAIT_ALU,
      UPDATE,
      HALT
   } state_t;

   state_t      state;
   logic [7:0]  pc_q;
   logic [15:0] instr_q;
   logic [15:0] last_result;
   logic        imem_req_q;
   logic        exec_valid_q;
   logic        halted_q;

   logic        is_branch;
   logic        br_taken;
   logic [7:0]  pc_next;

   assign is_branch = (instr_q[1:0] == 2'b10);

   always_comb begin
      br_taken = 1'b0;
      unique case (instr_q[3:2])
         2'b00: br_taken = (last_result == 16'd0);
         2'b01: br_taken = (last_result == 16'd1);
         2'b10: br_taken = (last_result == 16'd2);
         2'b11: br_taken = 1'b0;
      endcase
   end

   // 8-bit add wraps naturally at FF -> 00
   assign pc_next = (is_branch && br_taken) ? instr_q[11:4] : pc_q + 8'd1;

   // Strobes are registered: each is set on the edge that enters its state
   // and cleared on the edge that leaves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         last_result  <= '0;
         imem_req_q   <= 1'b0;
         exec_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.run) begin
                  state      <= FETCH;
                  imem_req_q <= 1'b1;
               end
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  instr_q    <= bus.imem_data;
                  imem_req_q <= 1'b0;
                  if (bus.imem_data == HALT_OPCODE) begin
                     state    <= HALT;
                     halted_q <= 1'b1;
                  end else begin
                     state        <= EXEC;
                     exec_valid_q <= 1'b1;
                  end
               end
            end
            EXEC: begin
               exec_valid_q <= 1'b0;
               state        <= is_branch ? UPDATE : WAIT_ALU;
            end
            WAIT_ALU: begin
               if (bus.alu_done) begin
                  last_result <= bus.alu_result;
                  state       <= UPDATE;
               end
            end
            UPDATE: begin
               pc_q <= pc_next;
               if (bus.run) begin
                  state      <= FETCH;
                  imem_req_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = pc_q;
   assign bus.instr      = instr_q;
   assign bus.exec_valid = exec_valid_q;
   assign bus.pc         = pc_q;
   assign bus.halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed bench for pc_sequencer.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_PC    (8'h00),
      .HALT_OPCODE (16'hFFFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered in FETCH; leaves one cycle after UPDATE (FETCH or IDLE).
   task automatic do_instr(input logic [15:0] word, input logic [15:0] res,
                           input int unsigned ack_delay, input bit drop_run);
      logic [7:0] addr0;
      addr0 = bus.imem_addr;
      bus.imem_data = word;
      for (int unsigned i = 0; i < ack_delay; i++) begin
         tick();
         chk("fetch_hold_req", {31'd0, bus.imem_req}, 32'd1);
         chk("fetch_hold_addr", {24'd0, bus.imem_addr}, {24'd0, addr0});
      end
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      chk("exec_pulse", {31'd0, bus.exec_valid}, 32'd1);
      chk("instr_latch", {16'd0, bus.instr}, {16'd0, word});
      chk("exec_req_low", {31'd0, bus.imem_req}, 32'd0);
      if (drop_run) bus.run = 1'b0;
      tick();
      chk("exec_once", {31'd0, bus.exec_valid}, 32'd0);
      if (word[1:0] != 2'b10) begin
         bus.alu_done   = 1'b1;
         bus.alu_result = res;
         tick();
         bus.alu_done = 1'b0;
         chk("update_pc_unchanged", {24'd0, bus.pc}, {24'd0, addr0});
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      bus.run = 1'b0; bus.imem_ack = 1'b0; bus.imem_data = '0;
      bus.alu_done = 1'b0; bus.alu_result = '0;
      tick();
      chk("rst_pc", {24'd0, bus.pc}, 32'h00);
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_exec", {31'd0, bus.exec_valid}, 32'd0);
      chk("rst_halted", {31'd0, bus.halted}, 32'd0);
      chk("rst_instr", {16'd0, bus.instr}, 32'd0);

      // IDLE holds while run=0
      rst = 1'b0;
      tick();
      chk("idle_no_req", {31'd0, bus.imem_req}, 32'd0);

      bus.run = 1'b1;
      tick();
      chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
      chk("fetch_addr", {24'd0, bus.imem_addr}, 32'h00);

      // ALU instr, result 0: pc 00 -> 01 after FETCH,EXEC,WAIT,UPDATE
      do_instr(16'h0001, 16'h0000, 0, 1'b0);
      chk("alu_pc", {24'd0, bus.pc}, 32'h01);
      chk("alu_next_fetch", {31'd0, bus.imem_req}, 32'd1);

      // BIE with last_result=0 -> taken to A3
      do_instr(16'h0A32, 16'h0, 0, 1'b0);
      chk("bie_taken", {24'd0, bus.imem_addr}, 32'hA3);
      // last_result=5 then BIE not taken
      do_instr(16'h0001, 16'h0005, 0, 1'b0);
      chk("alu_pc_a4", {24'd0, bus.pc}, 32'hA4);
      do_instr(16'h0A32, 16'h0, 0, 1'b0);
      chk("bie_not_taken", {24'd0, bus.pc}, 32'hA5);
      // last_result=1, BIG taken
      do_instr(16'h0001, 16'h0001, 0, 1'b0);
      do_instr(16'h0C56, 16'h0, 0, 1'b0);
      chk("big_taken", {24'd0, bus.pc}, 32'hC5);
      // last_result=2, BIL taken
      do_instr(16'h0001, 16'h0002, 0, 1'b0);
      do_instr(16'h0D7A, 16'h0, 0, 1'b0);
      chk("bil_taken", {24'd0, bus.pc}, 32'hD7);
      // never-taken at last_result=2 and 0
      do_instr(16'h0E8E, 16'h0, 0, 1'b0);
      chk("never_lr2", {24'd0, bus.pc}, 32'hD8);
      do_instr(16'h0001, 16'h0000, 0, 1'b0);
      do_instr(16'h0E8E, 16'h0, 0, 1'b0);
      chk("never_lr0", {24'd0, bus.pc}, 32'hDA);
      // branch to FF, then ALU instr with 5-cycle ack stall wraps to 00
      do_instr(16'h0FF2, 16'h0, 0, 1'b0);
      chk("bie_to_ff", {24'd0, bus.pc}, 32'hFF);
      do_instr(16'h0001, 16'h0003, 5, 1'b0);
      chk("pc_wrap", {24'd0, bus.pc}, 32'h00);

      // run dropped in EXEC: instruction completes, then IDLE
      do_instr(16'h0001, 16'h0000, 0, 1'b1);
      chk("drop_run_pc", {24'd0, bus.pc}, 32'h01);
      chk("drop_run_idle", {31'd0, bus.imem_req}, 32'd0);
      tick();
      chk("drop_run_stay", {31'd0, bus.imem_req}, 32'd0);

      // rst coincident with alu_done in WAIT_ALU
      bus.run = 1'b1;
      tick();
      chk("refetch_req", {31'd0, bus.imem_req}, 32'd1);
      bus.imem_data = 16'h0001; bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      tick();
      bus.alu_done = 1'b1; bus.alu_result = 16'h0005; rst = 1'b1;
      tick();
      rst = 1'b0; bus.alu_done = 1'b0; bus.run = 1'b0;
      chk("rst_wait_pc", {24'd0, bus.pc}, 32'h00);
      chk("rst_wait_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_wait_instr", {16'd0, bus.instr}, 32'd0);
      tick();
      chk("rst_wait_idle", {31'd0, bus.imem_req}, 32'd0);
      bus.run = 1'b1;
      tick();
      // last_result must have been cleared, so BIE is taken
      do_instr(16'h0A32, 16'h0, 0, 1'b0);
      chk("rst_cleared_lr", {24'd0, bus.pc}, 32'hA3);

      // HALT opcode
      bus.imem_data = 16'hFFFF; bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      chk("halt_flag", {31'd0, bus.halted}, 32'd1);
      chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_exec", {31'd0, bus.exec_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         bus.imem_ack = 1'b1; bus.alu_done = 1'b1;
         tick();
         chk("halt_stay", {31'd0, bus.halted}, 32'd1);
         chk("halt_no_req", {31'd0, bus.imem_req}, 32'd0);
         chk("halt_no_exec", {31'd0, bus.exec_valid}, 32'd0);
         chk("halt_pc", {24'd0, bus.pc}, 32'hA3);
      end
      bus.imem_ack = 1'b0; bus.alu_done = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("halt_rst_pc", {24'd0, bus.pc}, 32'h00);
      chk("halt_rst_flag", {31'd0, bus.halted}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
